// File: rtl/pinmux_pad_rx_filter.sv
// Receive-side conditioning for one pad: two-flop synchronizer, optional
// consecutive-cycle debounce, edge pulses and a saturating glitch counter.

package pinmux_pad_pkg;
    typedef enum logic [1:0] {
        BidirStd   = 2'd0,
        InputOnly  = 2'd1,
        OutputOnly = 2'd2,
        AnalogPad  = 2'd3
    } pad_type_e;
endpackage

module pinmux_pad_rx_filter
    import pinmux_pad_pkg::*;
#(
    parameter pad_type_e   PadType      = BidirStd,
    parameter int unsigned FilterCycles = 4,
    localparam int unsigned CntW        = (FilterCycles > 1) ? $clog2(FilterCycles) : 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       pad_i,
    input  logic       oe_i,
    input  logic       filter_en_i,
    input  logic       glitch_clr_i,
    output logic       in_o,
    output logic       rise_o,
    output logic       fall_o,
    output logic [7:0] glitch_cnt_o
);

    localparam logic [CntW-1:0] LastCnt = CntW'(FilterCycles - 1);

    function automatic logic [7:0] satInc(input logic [7:0] value);
        if (value == 8'hFF) begin
            return 8'hFF;
        end else begin
            return value + 8'd1;
        end
    endfunction

    logic            sync1R;
    logic            sync2R;
    logic            inR;
    logic            riseR;
    logic            fallR;
    logic [CntW-1:0] cntR;
    logic [7:0]      glitchR;

    logic            maskS;
    logic            differS;
    logic            updateS;
    logic            glitchIncS;
    logic            inNextS;
    logic [CntW-1:0] cntNextS;

    assign maskS   = (PadType == BidirStd) && oe_i;
    assign differS = (sync2R != inR);

    // Filter decision: when to accept sync2, advance the stability count, or flag a glitch
    always_comb begin
        inNextS    = inR;
        cntNextS   = cntR;
        updateS    = 1'b0;
        glitchIncS = 1'b0;
        if (maskS) begin
            cntNextS = '0;
        end else if (!filter_en_i) begin
            cntNextS = '0;
            if (differS) begin
                inNextS = sync2R;
                updateS = 1'b1;
            end else begin
                inNextS = inR;
            end
        end else if (differS && (cntR == LastCnt)) begin
            inNextS  = sync2R;
            cntNextS = '0;
            updateS  = 1'b1;
        end else if (differS) begin
            cntNextS = cntR + CntW'(1);
        end else if (cntR != '0) begin
            // sync2 fell back before the count completed
            cntNextS   = '0;
            glitchIncS = 1'b1;
        end else begin
            cntNextS = cntR;
        end
    end

    // Synchronizer, filter state, edge pulses and glitch counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1R  <= 1'b0;
            sync2R  <= 1'b0;
            inR     <= 1'b0;
            riseR   <= 1'b0;
            fallR   <= 1'b0;
            cntR    <= '0;
            glitchR <= 8'd0;
        end else begin
            sync1R <= pad_i;
            sync2R <= sync1R;
            inR    <= inNextS;
            cntR   <= cntNextS;
            riseR  <= updateS & sync2R & ~inR;
            fallR  <= updateS & ~sync2R & inR;
            if (glitch_clr_i) begin
                glitchR <= 8'd0;
            end else if (glitchIncS) begin
                glitchR <= satInc(glitchR);
            end else begin
                glitchR <= glitchR;
            end
        end
    end

    assign in_o         = inR;
    assign rise_o       = riseR;
    assign fall_o       = fallR;
    assign glitch_cnt_o = glitchR;

endmodule

// File: tb/tb_pinmux_pad_rx_filter.sv
// Directed bench for pinmux_pad_rx_filter: reset, debounce, glitch counting,
// output-enable masking, mode switching and the single-cycle filter case.

module tb_pinmux_pad_rx_filter;

    logic       clk;
    logic       rst;
    logic       pad;
    logic       oe;
    logic       filterEn;
    logic       glitchClr;
    logic       inO;
    logic       riseO;
    logic       fallO;
    logic [7:0] glitchCnt;

    logic       pad1;
    logic       in1;
    logic       rise1;
    logic       fall1;
    logic [7:0] glitch1;

    int errors = 0;
    int checks = 0;

    pinmux_pad_rx_filter #(.FilterCycles(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .pad_i        (pad),
        .oe_i         (oe),
        .filter_en_i  (filterEn),
        .glitch_clr_i (glitchClr),
        .in_o         (inO),
        .rise_o       (riseO),
        .fall_o       (fallO),
        .glitch_cnt_o (glitchCnt)
    );

    pinmux_pad_rx_filter #(.FilterCycles(1)) dut1 (
        .clk_i        (clk),
        .rst_i        (rst),
        .pad_i        (pad1),
        .oe_i         (1'b0),
        .filter_en_i  (1'b1),
        .glitch_clr_i (1'b0),
        .in_o         (in1),
        .rise_o       (rise1),
        .fall_o       (fall1),
        .glitch_cnt_o (glitch1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pad = 1'b0; oe = 1'b0; filterEn = 1'b0; glitchClr = 1'b0; pad1 = 1'b0;
        tick(2);
        checks++; if (inO !== 1'b0 || glitchCnt !== 8'd0) begin errors++; $display("FAIL reset_state: in=%b glitch=%0d expected 0/0", inO, glitchCnt); end
        rst = 1'b0;
        pad = 1'b1;
        tick(4);
        checks++; if (inO !== 1'b1) begin errors++; $display("FAIL pre_reset_level: in=%b expected 1", inO); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (inO !== 1'b0) begin errors++; $display("FAIL async_reset_in: in=%b expected 0", inO); end
        checks++; if (riseO !== 1'b0 || fallO !== 1'b0) begin errors++; $display("FAIL async_reset_pulse: rise=%b fall=%b expected 0/0", riseO, fallO); end
        checks++; if (glitchCnt !== 8'd0) begin errors++; $display("FAIL async_reset_glitch: glitch=%0d expected 0", glitchCnt); end
        tick(2);
        rst = 1'b0;
        tick(2);
        checks++; if (inO !== 1'b0) begin errors++; $display("FAIL release_latency_early: in=%b expected 0", inO); end
        tick(1);
        checks++; if (inO !== 1'b1 || riseO !== 1'b1) begin errors++; $display("FAIL release_rise: in=%b rise=%b expected 1/1", inO, riseO); end
        tick(1);
        checks++; if (inO !== 1'b1 || riseO !== 1'b0) begin errors++; $display("FAIL release_rise_single: in=%b rise=%b expected 1/0", inO, riseO); end
    endtask

    task automatic test_debounce();
        pad = 1'b0;
        tick(4);
        checks++; if (inO !== 1'b0) begin errors++; $display("FAIL debounce_setup: in=%b expected 0", inO); end
        filterEn = 1'b1;
        pad = 1'b1;
        tick(5);
        checks++; if (inO !== 1'b0 || riseO !== 1'b0) begin errors++; $display("FAIL debounce_rise_early: in=%b rise=%b expected 0/0", inO, riseO); end
        tick(1);
        checks++; if (inO !== 1'b1 || riseO !== 1'b1 || fallO !== 1'b0) begin errors++; $display("FAIL debounce_rise: in=%b rise=%b fall=%b expected 1/1/0", inO, riseO, fallO); end
        tick(1);
        checks++; if (riseO !== 1'b0) begin errors++; $display("FAIL debounce_rise_single: rise=%b expected 0", riseO); end
        pad = 1'b0;
        tick(5);
        checks++; if (inO !== 1'b1 || fallO !== 1'b0) begin errors++; $display("FAIL debounce_fall_early: in=%b fall=%b expected 1/0", inO, fallO); end
        tick(1);
        checks++; if (inO !== 1'b0 || fallO !== 1'b1 || riseO !== 1'b0) begin errors++; $display("FAIL debounce_fall: in=%b fall=%b rise=%b expected 0/1/0", inO, fallO, riseO); end
        tick(1);
        checks++; if (fallO !== 1'b0) begin errors++; $display("FAIL debounce_fall_single: fall=%b expected 0", fallO); end
        checks++; if (glitchCnt !== 8'd0) begin errors++; $display("FAIL debounce_no_glitch: glitch=%0d expected 0", glitchCnt); end
    endtask

    task automatic test_glitch();
        pad = 1'b1;
        tick(3);
        pad = 1'b0;
        tick(2);
        checks++; if (glitchCnt !== 8'd0 || inO !== 1'b0) begin errors++; $display("FAIL glitch_pending: glitch=%0d in=%b expected 0/0", glitchCnt, inO); end
        tick(1);
        checks++; if (glitchCnt !== 8'd1 || inO !== 1'b0) begin errors++; $display("FAIL glitch_first: glitch=%0d in=%b expected 1/0", glitchCnt, inO); end
        for (int i = 0; i < 299; i++) begin
            pad = 1'b1;
            tick(3);
            pad = 1'b0;
            tick(3);
        end
        checks++; if (glitchCnt !== 8'd255) begin errors++; $display("FAIL glitch_saturate: glitch=%0d expected 255", glitchCnt); end
        checks++; if (inO !== 1'b0) begin errors++; $display("FAIL glitch_level: in=%b expected 0", inO); end
        pad = 1'b1;
        tick(3);
        pad = 1'b0;
        tick(2);
        glitchClr = 1'b1;
        tick(1);
        glitchClr = 1'b0;
        checks++; if (glitchCnt !== 8'd0) begin errors++; $display("FAIL glitch_clear_priority: glitch=%0d expected 0", glitchCnt); end
    endtask

    task automatic test_oe_mask();
        logic [7:0] pattern;
        pattern = 8'b1110_0111;
        oe = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pad = pattern[i % 8];
            tick(1);
            checks++; if (inO !== 1'b0 || riseO !== 1'b0 || fallO !== 1'b0 || glitchCnt !== 8'd0) begin
                errors++; $display("FAIL oe_mask_hold[%0d]: in=%b rise=%b fall=%b glitch=%0d expected 0/0/0/0", i, inO, riseO, fallO, glitchCnt);
            end
        end
        pad = 1'b1;
        tick(6);
        checks++; if (inO !== 1'b0) begin errors++; $display("FAIL oe_mask_level: in=%b expected 0", inO); end
        oe = 1'b0;
        tick(3);
        checks++; if (inO !== 1'b0 || riseO !== 1'b0) begin errors++; $display("FAIL oe_release_early: in=%b rise=%b expected 0/0", inO, riseO); end
        tick(1);
        checks++; if (inO !== 1'b1 || riseO !== 1'b1) begin errors++; $display("FAIL oe_release_rise: in=%b rise=%b expected 1/1", inO, riseO); end
        tick(1);
        checks++; if (riseO !== 1'b0) begin errors++; $display("FAIL oe_release_single: rise=%b expected 0", riseO); end
    endtask

    task automatic test_mode_switch();
        pad = 1'b0;
        tick(4);
        checks++; if (inO !== 1'b1) begin errors++; $display("FAIL mode_switch_pre: in=%b expected 1", inO); end
        filterEn = 1'b0;
        tick(1);
        checks++; if (inO !== 1'b0 || fallO !== 1'b1) begin errors++; $display("FAIL mode_switch_follow: in=%b fall=%b expected 0/1", inO, fallO); end
        checks++; if (glitchCnt !== 8'd0) begin errors++; $display("FAIL mode_switch_glitch: glitch=%0d expected 0", glitchCnt); end
        tick(1);
        checks++; if (fallO !== 1'b0 || glitchCnt !== 8'd0) begin errors++; $display("FAIL mode_switch_after: fall=%b glitch=%0d expected 0/0", fallO, glitchCnt); end
        filterEn = 1'b1;
    endtask

    task automatic test_degenerate();
        logic s1m, s2m, inm, riseExp, fallExp;
        s1m = 1'b0; s2m = 1'b0; inm = 1'b0;
        checks++; if (in1 !== 1'b0) begin errors++; $display("FAIL degenerate_start: in=%b expected 0", in1); end
        for (int i = 0; i < 60; i++) begin
            pad1 = 1'($urandom_range(0, 1));
            tick(1);
            riseExp = s2m & ~inm;
            fallExp = ~s2m & inm;
            inm = s2m;
            s2m = s1m;
            s1m = pad1;
            checks++; if (in1 !== inm || rise1 !== riseExp || fall1 !== fallExp) begin
                errors++; $display("FAIL degenerate[%0d]: in=%b rise=%b fall=%b expected %b/%b/%b", i, in1, rise1, fall1, inm, riseExp, fallExp);
            end
        end
        checks++; if (glitch1 !== 8'd0) begin errors++; $display("FAIL degenerate_glitch: glitch=%0d expected 0", glitch1); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_glitch();
        test_oe_mask();
        test_mode_switch();
        test_degenerate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pinmux_pad_rx_filter.md
# pinmux_pad_rx_filter

Receive-side conditioning for one pad. It samples the raw asynchronous pad input through a two-flop synchronizer and applies an optional consecutive-cycle debounce filter. It produces a clean level plus single-cycle rise and fall pulses, and keeps a saturating count of rejected glitches. It sits between the pad attribute/wrapper hierarchy and the pinmux input routing, as the inbound counterpart to the pad-type configuration that flows outward to the pad.

## Interface
- `PadType`: `pad_type_e`, default `BidirStd`. When `BidirStd`, input is masked while the pad drives (`oe_i`).
- `FilterCycles`: default 4; legal range 1..65535. Number of consecutive stable synchronized cycles needed to accept a new level.
- `CntW`: derived, `max(1, $clog2(FilterCycles))`; not overridable.
- `clk_i` input 1: single clock.
- `rst_i` input 1: asynchronous, active-high reset.
- `pad_i` input 1: raw pad input, asynchronous to `clk_i`.
- `oe_i` input 1: pad output enable; 1 = pad is driving.
- `filter_en_i` input 1: 1 = debounce active; 0 = pass-through after sync.
- `glitch_clr_i` input 1: synchronous clear of `glitch_cnt_o`.
- `in_o` output 1: filtered, registered input level.
- `rise_o` output 1: one-cycle pulse, high in the cycle `in_o` becomes 1.
- `fall_o` output 1: one-cycle pulse, high in the cycle `in_o` becomes 0.
- `glitch_cnt_o` output 8: saturating count of rejected pulses.

## Operation
- Synchronizer: `sync1 <= pad_i`; `sync2 <= sync1`. Only `sync2` is used downstream.
- Masking is active when `PadType == BidirStd` and `oe_i == 1`:
  - `in_o` holds its value.
  - The counter is forced to 0.
  - No pulses are generated and no glitch is counted.
  - The synchronizer keeps running.
- `differ = (sync2 != in_o)`.
- Filter disabled, not masked: `in_o <= sync2` every cycle; the counter is held at 0.
- Filter enabled, not masked:
  - If `differ` and `cnt == FilterCycles-1`: `in_o <= sync2` and `cnt <= 0` (accept).
  - Else if `differ`: `cnt <= cnt + 1`.
  - Else, with `cnt != 0`: this is a rejected glitch. `cnt <= 0` and `glitch_cnt_o` increments.
  - Else: no change.
- Edge pulses are registered alongside `in_o`:
  - `rise_o <= update & sync2 & ~in_o`.
  - `fall_o <= update & ~sync2 & in_o`.
  - `update` is the cycle in which `in_o` is loaded with a differing value.
  - At most one of the two pulses is high in any cycle.
- `glitch_cnt_o` saturates at 255.
  - `glitch_clr_i` takes priority over an increment in the same cycle; the result is 0.
- Switching `filter_en_i` 1→0 mid-count: the counter clears. The next cycle behaves as pass-through, with no glitch counted.
- `FilterCycles == 1` behaves identically to the filter being disabled.

## Timing
- Reset: `sync1`, `sync2`, `in_o`, `cnt`, `rise_o`, `fall_o` and `glitch_cnt_o` all go to 0 immediately on `rst_i` assertion, asynchronously.
- Reset release: the first updates occur at the first `clk_i` edge after `rst_i` deasserts.
- Reset mid-count: everything clears. No pulse is emitted and no glitch is counted.
- Latency is measured from a `pad_i` change captured at edge *t*:
  - Filter off: `in_o`, `rise_o`/`fall_o` change after edge t+2 (3 edges).
  - Filter on, stable input: `in_o` changes after edge t+1+FilterCycles.
  - A pulse on `sync2` lasting fewer than `FilterCycles` cycles never reaches `in_o`. It increments `glitch_cnt_o` by exactly 1, one cycle after `sync2` returns.
- `oe_i` deassertion: filtering resumes with `cnt = 0` on the next edge. A level change that occurred while masked is then treated as a new transition.

## Test plan
- **Reset:** assert `rst_i` asynchronously mid-cycle with `pad_i=1` -> all outputs 0 immediately. After release with `filter_en_i=0`, `in_o=1` and `rise_o=1` for exactly one cycle, 3 edges after release.
- **Debounce accept:** `FilterCycles=4`, filter on, `pad_i` 0→1 held -> `in_o` rises 5 edges after capture, with a single `rise_o` pulse. Then 1→0 held gives a single `fall_o` pulse on the same latency.
- **Glitch reject:** `FilterCycles=4`, `pad_i` high for 3 cycles then low -> `in_o` stays 0 and `glitch_cnt_o` increments 0→1. Repeating 300 times -> `glitch_cnt_o=255`. Then `glitch_clr_i` in the same cycle as a new glitch -> `glitch_cnt_o=0`.
- **Output-enable mask:** `oe_i=1` with `pad_i` toggling -> `in_o` holds, no pulses, `glitch_cnt_o` unchanged. Drop `oe_i` with `pad_i=1` (`in_o` was 0) -> `rise_o` after `FilterCycles` cycles.
- **Mode switch:** `filter_en_i` 1→0 while `cnt=2` and `sync2 != in_o` -> `in_o` follows `sync2` on the next edge and `glitch_cnt_o` is unchanged.
- **Degenerate filter:** `FilterCycles=1` -> behaviour identical cycle-for-cycle to the filter-off case under random `pad_i` stimulus.
